// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: steps each instruction through
// fetch/decode/execute/memory/writeback and drives mux selects, write enables and ALU control.
module mips_multicycle_control #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_en,
    output logic [1:0]         pc_src,
    output logic               iord,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_control,
    output logic               retire,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     st;
    state_t     nxt;
    logic       is_sw;
    logic       funct_ok;
    logic [2:0] funct_alu;

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_ok  = 1'b0;
        endcase
    end

    // Memory handshake: a request (iord/mem_write/ir_write) is held every cycle until
    // the cycle in which mem_ready is high; that cycle completes the access.
    always_comb begin
        nxt = FETCH;
        case (st)
            FETCH:   nxt = mem_ready ? DECODE : FETCH;
            DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW)   nxt = MEMADR;
                else if (opcode == OP_RTYPE && funct_ok)  nxt = EXECUTE;
                else if (opcode == OP_BEQ)                nxt = BRANCH;
                else if (opcode == OP_ADDI)               nxt = ADDIEX;
                else if (opcode == OP_J)                  nxt = JUMP;
                else                                      nxt = FETCH;
            end
            MEMADR:  nxt = is_sw ? MEMWR : MEMRD;
            MEMRD:   nxt = mem_ready ? MEMWB : MEMRD;
            MEMWR:   nxt = mem_ready ? FETCH : MEMWR;
            EXECUTE: nxt = ALUWB;
            ADDIEX:  nxt = ADDIWB;
            default: nxt = FETCH;
        endcase
    end

    // The lw/sw choice is captured in DECODE so opcode is ignored once decode is past.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st    <= FETCH;
            is_sw <= 1'b0;
        end else begin
            st <= nxt;
            if (st == DECODE) is_sw <= (opcode == OP_SW);
        end
    end

    always_comb begin
        pc_en       = 1'b0;
        pc_src      = 2'b00;
        iord        = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        retire      = 1'b0;
        illegal     = 1'b0;
        case (st)
            FETCH: begin
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                illegal   = (nxt == FETCH);
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMRD: iord = 1'b1;
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                retire     = 1'b1;
            end
            MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                retire    = mem_ready;
            end
            EXECUTE: begin
                alu_src_a   = 1'b1;
                alu_control = funct_alu;
            end
            ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_src      = 2'b01;
                pc_en       = zero;
                retire      = 1'b1;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            ADDIWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            JUMP: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
                retire = 1'b1;
            end
            default: ;
        endcase
        // Reset silences everything at once, including the mem_ready-gated FETCH enables.
        if (reset) begin
            pc_en       = 1'b0;
            pc_src      = 2'b00;
            iord        = 1'b0;
            mem_write   = 1'b0;
            ir_write    = 1'b0;
            reg_dst     = 1'b0;
            mem_to_reg  = 1'b0;
            reg_write   = 1'b0;
            alu_src_a   = 1'b0;
            alu_src_b   = 2'b00;
            alu_control = ALU_ADD;
            retire      = 1'b0;
            illegal     = 1'b0;
        end
    end

    assign state = STATE_W'(st);

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Cycle-level bench for mips_multicycle_control: a reference model pushes the expected
// output vector each cycle, the scoreboard pops and compares it at the falling edge.
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic       retire;
    logic       illegal;
    logic [3:0] state;

    mips_multicycle_control #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .pc_src(pc_src), .iord(iord),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control), .retire(retire),
        .illegal(illegal), .state(state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // vector: pe ps[2] iord mw irw rd mtr rw sa sb[2] alu[3] ret ill st[4]
    localparam int B_ILL = 4, B_RET = 5, B_RW = 12, B_MW = 16;
    wire [20:0] obs_vec = {pc_en, pc_src, iord, mem_write, ir_write, reg_dst, mem_to_reg,
                           reg_write, alu_src_a, alu_src_b, alu_control, retire, illegal, state};

    logic [20:0] exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          m_st = 0;
    logic        m_sw = 1'b0;
    logic [20:0] last_exp;
    logic [20:0] last_obs;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic known_instr(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'd0) return (fn == 6'd32 || fn == 6'd34 || fn == 6'd36 || fn == 6'd37 || fn == 6'd42);
        return (op == 6'd35 || op == 6'd43 || op == 6'd4 || op == 6'd8 || op == 6'd2);
    endfunction

    function automatic logic [20:0] model_vec(input int st, input logic [5:0] op, input logic [5:0] fn,
                                              input logic z, input logic mr, input logic rst);
        logic pe, io, mw, irw, rd, mtr, rw, sa, ret, ill;
        logic [1:0] ps, sb;
        logic [2:0] ac;
        {pe, io, mw, irw, rd, mtr, rw, sa, ret, ill} = '0;
        ps = 2'b00; sb = 2'b00; ac = 3'b010;
        if (!rst) begin
            case (st)
                0:  begin sb = 2'b01; pe = mr; irw = mr; end
                1:  begin sb = 2'b11; ill = !known_instr(op, fn); end
                2:  begin sa = 1; sb = 2'b10; end
                3:  io = 1;
                4:  begin mtr = 1; rw = 1; ret = 1; end
                5:  begin io = 1; mw = 1; ret = mr; end
                6:  begin
                        sa = 1;
                        case (fn)
                            6'd34: ac = 3'b110;
                            6'd36: ac = 3'b000;
                            6'd37: ac = 3'b001;
                            6'd42: ac = 3'b111;
                            default: ac = 3'b010;
                        endcase
                    end
                7:  begin rd = 1; rw = 1; ret = 1; end
                8:  begin sa = 1; ac = 3'b110; ps = 2'b01; pe = z; ret = 1; end
                9:  begin sa = 1; sb = 2'b10; end
                10: begin rw = 1; ret = 1; end
                11: begin ps = 2'b10; pe = 1; ret = 1; end
                default: ;
            endcase
        end
        return {pe, ps, io, mw, irw, rd, mtr, rw, sa, sb, ac, ret, ill, (rst ? 4'd0 : 4'(st))};
    endfunction

    function automatic int model_next(input int st, input logic [5:0] op, input logic [5:0] fn,
                                      input logic mr, input logic sw);
        case (st)
            0: return mr ? 1 : 0;
            1: begin
                if (!known_instr(op, fn)) return 0;
                if (op == 6'd35 || op == 6'd43) return 2;
                if (op == 6'd0) return 6;
                if (op == 6'd4) return 8;
                if (op == 6'd8) return 9;
                return 11;
            end
            2: return sw ? 5 : 3;
            3: return mr ? 4 : 3;
            5: return mr ? 0 : 5;
            6: return 7;
            9: return 10;
            default: return 0;
        endcase
    endfunction

    // driver: one clock cycle, inputs applied 1 time unit after the rising edge
    task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic z,
                        input logic mr, input logic rst);
        opcode = op; funct = fn; zero = z; mem_ready = mr; reset = rst;
        exp_q.push_back(model_vec(m_st, op, fn, z, mr, rst));
        @(negedge clk);
        last_obs = obs_vec;
        last_exp = exp_q.pop_front();
        check_eq($sformatf("vec_st%0d", m_st), 32'(last_obs), 32'(last_exp));
        if (rst) begin
            m_st = 0;
            m_sw = 1'b0;
        end else begin
            int n;
            n = model_next(m_st, op, fn, mr, m_sw);
            if (m_st == 1) m_sw = (op == 6'd43);
            m_st = n;
        end
        @(posedge clk);
        #1;
    endtask

    // One instruction from FETCH to retire/illegal; opcode/funct are garbage outside
    // DECODE/EXECUTE, mem_ready is low for fs FETCH cycles and ms MEMRD/MEMWR cycles.
    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int fs, input int ms,
                             input int exp_cyc, input int exp_ret, input int exp_mw, input int exp_rw);
        int cyc = 0, fc = 0, mc = 0, n_ret = 0, n_mw = 0, n_rw = 0;
        logic [5:0] o, f;
        logic mr, zz;
        bit done = 0;
        while (!done && cyc < 20) begin
            o  = (m_st == 1 || m_st == 6) ? op : 6'($urandom_range(0, 63));
            f  = (m_st == 1 || m_st == 6) ? fn : 6'($urandom_range(0, 63));
            zz = (m_st == 8) ? z : 1'($urandom_range(0, 1));
            if (m_st == 0) begin mr = (fc >= fs); fc++; end
            else if (m_st == 3 || m_st == 5) begin mr = (mc >= ms); mc++; end
            else mr = 1'($urandom_range(0, 1));
            step(o, f, zz, mr, 1'b0);
            cyc++;
            n_ret += int'(last_obs[B_RET]);
            n_mw  += int'(last_obs[B_MW]);
            n_rw  += int'(last_obs[B_RW]);
            done = last_exp[B_RET] || last_exp[B_ILL];
        end
        check_eq({name, "_cycles"}, 32'(cyc), 32'(exp_cyc));
        check_eq({name, "_retires"}, 32'(n_ret), 32'(exp_ret));
        check_eq({name, "_memwr_cycles"}, 32'(n_mw), 32'(exp_mw));
        check_eq({name, "_regwr_cycles"}, 32'(n_rw), 32'(exp_rw));
        check_eq({name, "_back_to_fetch"}, 32'(state), 32'd0);
    endtask

    initial begin
        reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // reset held: mem_ready high must not leak into ir_write/pc_en
        step(6'd35, 6'd0, 1'b1, 1'b1, 1'b1);
        step(6'd35, 6'd0, 1'b1, 1'b0, 1'b1);

        run_instr("lw",       6'd35, 6'd0,  1'b0, 0, 0, 5, 1, 0, 1);
        run_instr("sw_stall", 6'd43, 6'd0,  1'b0, 0, 3, 7, 1, 4, 0);
        run_instr("sub",      6'd0,  6'd34, 1'b0, 0, 0, 4, 1, 0, 1);
        run_instr("beq_t",    6'd4,  6'd0,  1'b1, 0, 0, 3, 1, 0, 0);
        run_instr("beq_nt",   6'd4,  6'd0,  1'b0, 0, 0, 3, 1, 0, 0);
        run_instr("ill_op",   6'd63, 6'd0,  1'b0, 0, 0, 2, 0, 0, 0);
        run_instr("ill_fn",   6'd0,  6'd7,  1'b0, 0, 0, 2, 0, 0, 0);
        run_instr("addi_fs2", 6'd8,  6'd0,  1'b0, 2, 0, 6, 1, 0, 1);
        run_instr("j",        6'd2,  6'd0,  1'b0, 0, 0, 3, 1, 0, 0);
        run_instr("lw_stall", 6'd35, 6'd0,  1'b0, 1, 2, 8, 1, 0, 1);
        run_instr("slt",      6'd0,  6'd42, 1'b0, 0, 0, 4, 1, 0, 1);

        // reset in MEMRD with FETCH mem_ready toggling beforehand
        step(6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
        step(6'd0, 6'd0, 1'b0, 1'b1, 1'b0);
        step(6'd35, 6'd0, 1'b0, 1'b1, 1'b0);
        step(6'd0, 6'd0, 1'b0, 1'b1, 1'b0);
        step(6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
        check_eq("in_memrd", 32'(state), 32'd3);
        step(6'd0, 6'd0, 1'b0, 1'b1, 1'b1);
        check_eq("rst_mid_retire", 32'(last_obs[B_RET]), 32'd0);
        step(6'd0, 6'd0, 1'b0, 1'b1, 1'b1);
        run_instr("addi_after_rst", 6'd8, 6'd0, 1'b0, 2, 0, 6, 1, 0, 1);

        // random mix with random stalls
        for (int k = 0; k < 12; k++) begin
            int sel, fs, ms, cyc, rw, mw, rt;
            logic [5:0] op, fn;
            logic z;
            sel = $urandom_range(0, 6);
            fs = $urandom_range(0, 3);
            ms = $urandom_range(0, 3);
            z = 1'($urandom_range(0, 1));
            fn = 6'd32;
            case (sel)
                0: begin op = 6'd35; cyc = 5 + fs + ms; rw = 1; mw = 0;      end
                1: begin op = 6'd43; cyc = 4 + fs + ms; rw = 0; mw = ms + 1; end
                2: begin op = 6'd0;  fn = 6'd37; cyc = 4 + fs; rw = 1; mw = 0; end
                3: begin op = 6'd4;  cyc = 3 + fs; rw = 0; mw = 0; end
                4: begin op = 6'd8;  cyc = 4 + fs; rw = 1; mw = 0; end
                5: begin op = 6'd2;  cyc = 3 + fs; rw = 0; mw = 0; end
                default: begin op = 6'd0; fn = 6'd36; cyc = 4 + fs; rw = 1; mw = 0; end
            endcase
            rt = 1;
            run_instr($sformatf("rnd%0d", k), op, fn, z, fs, ms, cyc, rt, mw, rw);
        end

        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
